// File: rtl/snoop_pkg.sv
// Shared types and constants for the snoop arbiter.
package snoop_pkg;

  typedef logic [2:0] acprot_t;
  typedef logic [3:0] acsnoop_t;
  typedef logic [4:0] resp_t;

  localparam int unsigned RespDataTransferBit = 0;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbSendAc,
    ArbWaitCr,
    ArbWaitCd
  } arb_state_e;

endpackage

// File: rtl/snoop_rr_select.sv
// Combinational round-robin picker: the first valid bit at or after ptr_i,
// wrapping from NoReq-1 back to 0.
module snoop_rr_select #(
  parameter int unsigned NoReq = 2,
  parameter int unsigned IdxW  = (NoReq > 1) ? $clog2(NoReq) : 1
) (
  input  logic [NoReq-1:0] valid_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [NoReq-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  int unsigned cand;

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NoReq; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NoReq) cand = cand - NoReq;
      if (!any_o && valid_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = IdxW'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_arbiter.sv
// Round-robin arbiter sharing one snoop (AC/CR/CD) port among NoReq initiators,
// with a single outstanding snoop and responses routed back to the granted one.
module snoop_arbiter
  import snoop_pkg::*;
#(
  parameter int unsigned NoReq     = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned IdxW     = (NoReq > 1) ? $clog2(NoReq) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NoReq-1:0][AddrWidth-1:0] req_ac_addr_i,
  input  acprot_t  [NoReq-1:0]            req_ac_prot_i,
  input  acsnoop_t [NoReq-1:0]            req_ac_snoop_i,
  input  logic [NoReq-1:0]                req_ac_valid_i,
  output logic [NoReq-1:0]                req_ac_ready_o,
  output resp_t                           req_cr_resp_o,
  output logic [NoReq-1:0]                req_cr_valid_o,
  input  logic [NoReq-1:0]                req_cr_ready_i,
  output logic [DataWidth-1:0]            req_cd_data_o,
  output logic                            req_cd_last_o,
  output logic [NoReq-1:0]                req_cd_valid_o,
  input  logic [NoReq-1:0]                req_cd_ready_i,
  output logic [AddrWidth-1:0]            ac_addr_o,
  output acprot_t                         ac_prot_o,
  output acsnoop_t                        ac_snoop_o,
  output logic                            ac_valid_o,
  input  logic                            ac_ready_i,
  input  resp_t                           cr_resp_i,
  input  logic                            cr_valid_i,
  output logic                            cr_ready_o,
  input  logic [DataWidth-1:0]            cd_data_i,
  input  logic                            cd_last_i,
  input  logic                            cd_valid_i,
  output logic                            cd_ready_o,
  output logic                            busy_o,
  output logic [IdxW-1:0]                 grant_idx_o
);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, gnt_idx_q;
  logic [AddrWidth-1:0] addr_q;
  acprot_t              prot_q;
  acsnoop_t             snoop_q;

  logic [NoReq-1:0] sel_gnt;
  logic [IdxW-1:0]  sel_idx;
  logic             sel_any;
  logic             load;

  snoop_rr_select #(
    .NoReq (NoReq),
    .IdxW  (IdxW)
  ) u_rr_select (
    .valid_i (req_ac_valid_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  always_comb begin
    state_d        = state_q;
    load           = 1'b0;
    req_ac_ready_o = '0;
    req_cr_valid_o = '0;
    req_cr_resp_o  = '0;
    req_cd_valid_o = '0;
    req_cd_data_o  = '0;
    req_cd_last_o  = 1'b0;
    ac_valid_o     = 1'b0;
    cr_ready_o     = 1'b0;
    cd_ready_o     = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        // Qualified by rst_ni so every output reads 0 while reset is held.
        if (sel_any && rst_ni) begin
          req_ac_ready_o = sel_gnt;
          load           = 1'b1;
          state_d        = ArbSendAc;
        end
      end
      ArbSendAc: begin
        ac_valid_o = 1'b1;
        if (ac_ready_i) state_d = ArbWaitCr;
      end
      ArbWaitCr: begin
        req_cr_valid_o[gnt_idx_q] = cr_valid_i;
        req_cr_resp_o             = cr_resp_i;
        cr_ready_o                = req_cr_ready_i[gnt_idx_q];
        if (cr_valid_i && req_cr_ready_i[gnt_idx_q]) begin
          state_d = cr_resp_i[RespDataTransferBit] ? ArbWaitCd : ArbIdle;
        end
      end
      ArbWaitCd: begin
        req_cd_valid_o[gnt_idx_q] = cd_valid_i;
        req_cd_data_o             = cd_data_i;
        req_cd_last_o             = cd_last_i;
        cd_ready_o                = req_cd_ready_i[gnt_idx_q];
        if (cd_valid_i && req_cd_ready_i[gnt_idx_q] && cd_last_i) state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
  end

  // NOTE: the payload registers are reset as well, so ac_*_o read 0 after
  // reset rather than a stale address from an abandoned snoop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ArbIdle;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      addr_q    <= '0;
      prot_q    <= '0;
      snoop_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      if (load) begin
        gnt_idx_q <= sel_idx;
        rr_ptr_q  <= (sel_idx == IdxW'(NoReq - 1)) ? '0 : sel_idx + 1'b1;
        addr_q    <= req_ac_addr_i[sel_idx];
        prot_q    <= req_ac_prot_i[sel_idx];
        snoop_q   <= req_ac_snoop_i[sel_idx];
      end
    end
  end

  assign ac_addr_o   = addr_q;
  assign ac_prot_o   = prot_q;
  assign ac_snoop_o  = snoop_q;
  assign busy_o      = (state_q != ArbIdle);
  assign grant_idx_o = gnt_idx_q;

endmodule

// File: tb/tb_snoop_arbiter.sv
// Directed bench for snoop_arbiter with two requesters and hand-computed expectations.
module tb_snoop_arbiter;
  import snoop_pkg::*;

  localparam int unsigned NoReq = 2;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [NoReq-1:0][AW-1:0] req_ac_addr_i;
  acprot_t  [NoReq-1:0]     req_ac_prot_i;
  acsnoop_t [NoReq-1:0]     req_ac_snoop_i;
  logic [NoReq-1:0]         req_ac_valid_i;
  logic [NoReq-1:0]         req_ac_ready_o;
  resp_t                    req_cr_resp_o;
  logic [NoReq-1:0]         req_cr_valid_o;
  logic [NoReq-1:0]         req_cr_ready_i;
  logic [DW-1:0]            req_cd_data_o;
  logic                     req_cd_last_o;
  logic [NoReq-1:0]         req_cd_valid_o;
  logic [NoReq-1:0]         req_cd_ready_i;
  logic [AW-1:0]            ac_addr_o;
  acprot_t                  ac_prot_o;
  acsnoop_t                 ac_snoop_o;
  logic                     ac_valid_o;
  logic                     ac_ready_i;
  resp_t                    cr_resp_i;
  logic                     cr_valid_i;
  logic                     cr_ready_o;
  logic [DW-1:0]            cd_data_i;
  logic                     cd_last_i;
  logic                     cd_valid_i;
  logic                     cd_ready_o;
  logic                     busy_o;
  logic                     grant_idx_o;

  int n_checks = 0;
  int n_pass   = 0;

  snoop_arbiter #(.NoReq(NoReq), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_ac_addr_i  (req_ac_addr_i),
    .req_ac_prot_i  (req_ac_prot_i),
    .req_ac_snoop_i (req_ac_snoop_i),
    .req_ac_valid_i (req_ac_valid_i),
    .req_ac_ready_o (req_ac_ready_o),
    .req_cr_resp_o  (req_cr_resp_o),
    .req_cr_valid_o (req_cr_valid_o),
    .req_cr_ready_i (req_cr_ready_i),
    .req_cd_data_o  (req_cd_data_o),
    .req_cd_last_o  (req_cd_last_o),
    .req_cd_valid_o (req_cd_valid_o),
    .req_cd_ready_i (req_cd_ready_i),
    .ac_addr_o      (ac_addr_o),
    .ac_prot_o      (ac_prot_o),
    .ac_snoop_o     (ac_snoop_o),
    .ac_valid_o     (ac_valid_o),
    .ac_ready_i     (ac_ready_i),
    .cr_resp_i      (cr_resp_i),
    .cr_valid_i     (cr_valid_i),
    .cr_ready_o     (cr_ready_o),
    .cd_data_i      (cd_data_i),
    .cd_last_i      (cd_last_i),
    .cd_valid_i     (cd_valid_i),
    .cd_ready_o     (cd_ready_o),
    .busy_o         (busy_o),
    .grant_idx_o    (grant_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // From IDLE: present valids, check same-cycle ready, then check SEND_AC payload.
  task automatic start_snoop(input logic [1:0] valids, input int exp_g);
    req_ac_valid_i = valids;
    #1;
    check("ac_ready_same_cycle", 64'(req_ac_ready_o), 64'(2'b01 << exp_g));
    step();
    check("grant_idx", 64'(grant_idx_o), 64'(exp_g));
    check("ac_valid_rise", 64'(ac_valid_o), 64'd1);
    check("ac_addr", ac_addr_o, (exp_g == 0) ? 64'h2000 : 64'h1000);
  endtask

  task automatic ac_handshake();
    ac_ready_i = 1'b1;
    step();
    ac_ready_i = 1'b0;
  endtask

  // In WAIT_CR: one CR handshake with the given response.
  task automatic cr_handshake(input resp_t resp, input int exp_g);
    cr_valid_i = 1'b1;
    cr_resp_i  = resp;
    #1;
    check("cr_valid_route", 64'(req_cr_valid_o), 64'(2'b01 << exp_g));
    check("cr_resp_pass", 64'(req_cr_resp_o), 64'(resp));
    step();
    cr_valid_i = 1'b0;
    cr_resp_i  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni         = 1'b0;
    req_ac_addr_i  = '0;
    req_ac_addr_i[0] = 64'h2000;
    req_ac_addr_i[1] = 64'h1000;
    req_ac_prot_i  = '0;
    req_ac_prot_i[1] = 3'b010;
    req_ac_snoop_i = '0;
    req_ac_snoop_i[0] = 4'h2;
    req_ac_snoop_i[1] = 4'h1;
    req_ac_valid_i = '0;
    req_cr_ready_i = 2'b11;
    req_cd_ready_i = '0;
    ac_ready_i     = 1'b0;
    cr_resp_i      = '0;
    cr_valid_i     = 1'b0;
    cd_data_i      = '0;
    cd_last_i      = 1'b0;
    cd_valid_i     = 1'b0;
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ac_valid", 64'(ac_valid_o), 64'd0);
    check("rst_ac_addr", ac_addr_o, 64'd0);
    check("rst_grant", 64'(grant_idx_o), 64'd0);
    step();
    step();
    rst_ni = 1'b1;
    step();

    // Single snoop without data from requester 1.
    start_snoop(2'b10, 1);
    req_ac_valid_i = '0;
    check("t1_snoop", 64'(ac_snoop_o), 64'h1);
    check("t1_prot", 64'(ac_prot_o), 64'(3'b010));
    check("t1_busy", 64'(busy_o), 64'd1);
    ac_handshake();
    cr_handshake(5'h00, 1);
    #1;
    check("t1_busy_fall", 64'(busy_o), 64'd0);

    // Round-robin with both requesters continuously valid.
    for (int k = 0; k < 4; k++) begin
      start_snoop(2'b11, k % 2);
      check("t2_no_ready_in_send", 64'(req_ac_ready_o), 64'd0);
      ac_handshake();
      cr_handshake(5'h00, k % 2);
    end
    req_ac_valid_i = '0;

    // Data transfer to requester 0 with a toggling CD ready.
    start_snoop(2'b01, 0);
    req_ac_valid_i = '0;
    ac_handshake();
    cr_handshake(5'h01, 0);
    begin
      int beat = 0;
      int cyc  = 0;
      logic rdy = 1'b0;
      cd_valid_i = 1'b1;
      while (beat < 4 && cyc < 20) begin
        cd_data_i      = 64'hA0 + 64'(beat);
        cd_last_i      = (beat == 3);
        req_cd_ready_i = {1'b1, rdy};
        #1;
        check("t3_cd_valid_route", 64'(req_cd_valid_o), 64'b01);
        check("t3_cd_data", req_cd_data_o, 64'hA0 + 64'(beat));
        check("t3_cd_ready", 64'(cd_ready_o), 64'(rdy));
        step();
        if (rdy) beat++;
        rdy = ~rdy;
        cyc++;
      end
      check("t3_beats_done", 64'(beat), 64'd4);
      cd_valid_i     = 1'b0;
      cd_last_i      = 1'b0;
      req_cd_ready_i = '0;
      #1;
      check("t3_idle_after_last", 64'(busy_o), 64'd0);
    end

    // AC backpressure and early CR: rr_ptr is 1, so requester 1 wins.
    start_snoop(2'b11, 1);
    cr_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t4_addr_stable", ac_addr_o, 64'h1000);
      check("t4_snoop_stable", 64'(ac_snoop_o), 64'h1);
      check("t4_no_regrant", 64'(req_ac_ready_o), 64'd0);
      check("t5_cr_ready_low", 64'(cr_ready_o), 64'd0);
      check("t5_cr_valid_low", 64'(req_cr_valid_o), 64'd0);
      step();
    end
    req_ac_valid_i = '0;
    ac_ready_i = 1'b1;
    #1;
    check("t5_cr_ready_at_ac_hs", 64'(cr_ready_o), 64'd0);
    step();
    ac_ready_i = 1'b0;
    #1;
    check("t5_cr_ready_after", 64'(cr_ready_o), 64'd1);
    check("t4_grant_held", 64'(grant_idx_o), 64'd1);
    step();
    cr_valid_i = 1'b0;

    // Reset during beat 2 of a burst granted to requester 0 (rr_ptr then 1).
    start_snoop(2'b01, 0);
    req_ac_valid_i = '0;
    ac_handshake();
    cr_handshake(5'h01, 0);
    cd_valid_i = 1'b1;
    req_cd_ready_i = 2'b01;
    cd_data_i  = 64'hA0;
    step();
    cd_data_i  = 64'hA1;
    #1;
    check("t6_beat2_seen", 64'(req_cd_valid_o), 64'b01);
    req_ac_valid_i = 2'b11;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_cd_valid", 64'(req_cd_valid_o), 64'd0);
    check("t6_rst_cd_data", req_cd_data_o, 64'd0);
    check("t6_rst_cd_ready", 64'(cd_ready_o), 64'd0);
    check("t6_rst_busy", 64'(busy_o), 64'd0);
    check("t6_rst_ac_addr", ac_addr_o, 64'd0);
    check("t6_rst_ac_ready", 64'(req_ac_ready_o), 64'd0);
    step();
    rst_ni = 1'b1;
    #1;
    check("t6_no_beats_after", 64'(req_cd_valid_o), 64'd0);
    check("t6_ptr_reset_grant", 64'(req_ac_ready_o), 64'b01);
    step();
    check("t6_grant_idx", 64'(grant_idx_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
